// File: rtl/shared_reg_arb_pkg.sv
// Shared types and helpers for the shared-register round-robin arbiter.
// Used by both the default build and the SHARED_REG_ARB_LOCK_EN build.
package shared_reg_arb_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;

    typedef logic [DEFAULT_N-1:0] gnt_vec_t;

    // A single requester still gets a 1-bit index so no port collapses to zero width.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching from ptr upward, wrapping modulo N.
module rr_pick
    import shared_reg_arb_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int IW = id_width(DEFAULT_N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int            cand;
    logic [IW-1:0] cand_idx;

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!any && req[cand_idx]) begin
                any           = 1'b1;
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter writing the granted requester's data into one shared register.
// Define SHARED_REG_ARB_LOCK_EN to add lock_i, letting the current grantee keep the register.
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int             N       = DEFAULT_N,
    parameter int             W       = DEFAULT_W,
    parameter logic [W-1:0]   RST_VAL = '0,
    localparam int            IW      = id_width(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req_i,
    input  logic [N-1:0][W-1:0] data_i,
`ifdef SHARED_REG_ARB_LOCK_EN
    input  logic [N-1:0]        lock_i,
`endif
    output logic [N-1:0]        gnt_o,
    output logic [W-1:0]        q_o,
    output logic                q_valid_o,
    output logic [IW-1:0]       gnt_id_o
);

    logic [W-1:0]  q_q,       q_d;
    logic          q_valid_q, q_valid_d;
    logic [IW-1:0] gnt_id_q,  gnt_id_d;
    logic [IW-1:0] ptr_q,     ptr_d;

    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    logic [N-1:0]  win_gnt;
    logic [IW-1:0] win_idx;
    logic          win_any;
    logic          lock_hold;

    rr_pick #(.N(N), .IW(IW)) u_rr_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Lock ownership is last cycle's grantee; q_valid_q says there was one, and reset clears it.
`ifdef SHARED_REG_ARB_LOCK_EN
    assign lock_hold = q_valid_q & req_i[gnt_id_q] & lock_i[gnt_id_q];
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        win_gnt   = pick_gnt;
        win_idx   = pick_idx;
        win_any   = pick_any;
        q_d       = q_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        q_valid_d = 1'b0;

        if (lock_hold) begin
            win_gnt           = '0;
            win_gnt[gnt_id_q] = 1'b1;
            win_idx           = gnt_id_q;
            win_any           = 1'b1;
        end
        if (reset) begin
            win_gnt = '0;
            win_any = 1'b0;
        end

        if (win_any) begin
            q_d       = data_i[win_idx];
            gnt_id_d  = win_idx;
            q_valid_d = 1'b1;
            // A locked re-grant leaves the pointer alone so round-robin resumes where it was.
            if (!lock_hold) begin
                ptr_d = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q       <= RST_VAL;
            q_valid_q <= 1'b0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt_o     = win_gnt;
    assign q_o       = q_q;
    assign q_valid_o = q_valid_q;
    assign gnt_id_o  = gnt_id_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios then randomized traffic against a reference model.
// Lock scenarios are exercised only when SHARED_REG_ARB_LOCK_EN is defined.
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic                clk;
    logic                reset;
    logic [N-1:0]        req_i;
    logic [N-1:0][W-1:0] data_i;
`ifdef SHARED_REG_ARB_LOCK_EN
    logic [N-1:0]        lock_i;
`endif
    logic [N-1:0]        gnt_o;
    logic [W-1:0]        q_o;
    logic                q_valid_o;
    logic [1:0]          gnt_id_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state, kept as plain integers.
    int         m_ptr   = 0;
    int         m_id    = 0;
    bit         m_valid = 0;
    logic [7:0] m_q     = 8'h00;

    shared_reg_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .data_i    (data_i),
`ifdef SHARED_REG_ARB_LOCK_EN
        .lock_i    (lock_i),
`endif
        .gnt_o     (gnt_o),
        .q_o       (q_o),
        .q_valid_o (q_valid_o),
        .gnt_id_o  (gnt_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner = the requester with the smallest forward distance from the pointer,
    // unless last cycle's grantee still requests with its lock raised.
    function automatic int exp_winner(input logic [N-1:0] req, input logic [N-1:0] lock);
        int best  = -1;
        int bestd = N;
        if (m_valid && req[m_id] && lock[m_id]) return m_id;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                int d = (i - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // One cycle: drive at posedge+1, check grant mid-cycle, check registered outputs after the edge.
    task automatic step(input logic rst, input logic [N-1:0] req,
                        input logic [N-1:0][W-1:0] data, input logic [N-1:0] lock);
        int         w;
        bit         locked;
        logic [N-1:0] lk;
`ifdef SHARED_REG_ARB_LOCK_EN
        lk = lock;
`else
        lk = '0;
`endif
        reset = rst;
        req_i = req;
        data_i = data;
`ifdef SHARED_REG_ARB_LOCK_EN
        lock_i = lock;
`endif
        #4;
        w = rst ? -1 : exp_winner(req, lk);
        locked = !rst && m_valid && req[m_id] && lk[m_id];
        check("gnt", 32'(gnt_o), (w < 0) ? 32'd0 : (32'd1 << w));
        @(posedge clk);
        #1;
        if (rst) begin
            m_q = 8'h00; m_valid = 0; m_id = 0; m_ptr = 0;
        end else if (w >= 0) begin
            m_q = data[w]; m_valid = 1; m_id = w;
            if (!locked) m_ptr = (w + 1) % N;
        end else begin
            m_valid = 0;
        end
        check("q", 32'(q_o), 32'(m_q));
        check("q_valid", 32'(q_valid_o), 32'(m_valid));
        check("gnt_id", 32'(gnt_id_o), 32'(m_id));
    endtask

    initial begin
        logic [N-1:0][W-1:0] d;
        logic [N-1:0][W-1:0] rd;
        reset = 1'b1;
        req_i = '0;
        data_i = '0;
`ifdef SHARED_REG_ARB_LOCK_EN
        lock_i = '0;
`endif
        @(posedge clk);
        #1;

        d = {8'h33, 8'h22, 8'h11, 8'h00};
        // Reset with every requester active, then full contention.
        repeat (2) step(1'b1, 4'b1111, d, 4'b0000);
        check("rst_q_const", 32'(q_o), 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, d, 4'b0000);

        // Pointer wrap and skip: grant 2, then 0, then 1.
        step(1'b0, 4'b0100, d, 4'b0000);
        step(1'b0, 4'b0011, d, 4'b0000);
        check("wrap_id0", 32'(gnt_id_o), 32'd0);
        step(1'b0, 4'b0011, d, 4'b0000);
        check("wrap_id1", 32'(gnt_id_o), 32'd1);

        // Idle hold after loading 5A.
        d[2] = 8'h5A;
        step(1'b0, 4'b0100, d, 4'b0000);
        repeat (3) step(1'b0, 4'b0000, d, 4'b0000);
        check("idle_q_const", 32'(q_o), 32'h5A);

        // Reset mid-operation drops the pending grant; requester 0 wins first afterwards.
        step(1'b1, 4'b0100, d, 4'b0000);
        step(1'b0, 4'b1111, d, 4'b0000);
        check("post_rst_id", 32'(gnt_id_o), 32'd0);

        // Lock: requester 1 holds for four cycles, then 2 wins on release.
        repeat (4) step(1'b0, 4'b0110, d, 4'b0010);
        step(1'b0, 4'b0110, d, 4'b0000);

        // Single requester back-to-back.
        repeat (3) step(1'b0, 4'b1000, d, 4'b0000);

        // Randomized traffic with occasional resets and bursts of lock.
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] rl;
            for (int k = 0; k < N; k++) rd[k] = W'($urandom);
            rl = ($urandom_range(0, 3) == 0) ? 4'b1111 : N'($urandom);
            step($urandom_range(0, 24) == 0, N'($urandom), rd, rl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
